coin_dispenser: RTL and testbench
=================================

# coin_dispenser

Change-payout sequencer for the vending machine: the opposite direction of the coin-acceptor path that takes r1/r2/r5 inserts. It accepts a change amount from the vending controller and pays it back as timed eject pulses to three coin hoppers (5, 2 and 1 units). It picks coins greedily, largest first, and skips any hopper flagged empty. When finished it reports a one-cycle done and any amount it could not pay.

## Interface
Parameters:
- AMT_W, 8, width of change amount and shortfall.
- PULSE_CYC, 4, cycles each eject pulse is held high (≥1).
- GAP_CYC, 4, low cycles after each pulse before the next selection (≥1).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  change request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_amount  in  AMT_W  change to pay, unsigned; sampled on handshake.
- empty5, empty2, empty1  in  1 each  hopper empty flags.
- eject5, eject2, eject1  out  1 each  hopper eject pulses.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion strobe.
- short_amt  out  AMT_W  unpaid remainder; valid while done=1, held until next handshake.

## Operation
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: req_ready=1. A handshake (req_valid && req_ready at a clock edge) loads remaining←req_amount and moves to SELECT. req_valid outside IDLE is ignored.
- SELECT (one cycle): evaluate in priority order and latch the chosen coin.
  - remaining≥5 && !empty5 → coin 5.
  - else remaining≥2 && !empty2 → coin 2.
  - else remaining≥1 && !empty1 → coin 1.
  - else → DONE.
- On leaving SELECT for PULSE, remaining is decremented by the coin value. It never underflows because the coin value is always ≤ remaining.
- PULSE: exactly one eject line is high for PULSE_CYC cycles, then GAP.
- GAP: all eject lines low for GAP_CYC cycles, then SELECT.
- DONE (one cycle): done=1 and short_amt←remaining, then IDLE.
- Empty flags are sampled only in SELECT. A hopper going empty during PULSE or GAP does not abort the current coin.
- Greedy is not optimal with empty hoppers. Example: 6 with empty1=1 pays 5 and then reports short_amt=1. This is the required behaviour.
- Zero amount passes through SELECT straight to DONE with short_amt=0.
- Reset (asynchronous, active-low): state=IDLE, remaining=0.
  - All eject lines, done and busy are 0; short_amt=0.
  - Applies mid-pulse as well: the pulse is truncated and no done is issued.
  - req_ready=1 from reset release.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Handshake at edge 0 → SELECT during cycle 1.
- Each paid coin costs 1 + PULSE_CYC + GAP_CYC cycles.
- For n coins, done is high in cycle n·(1+PULSE_CYC+GAP_CYC)+2. With defaults: 9n+2.
- The next request can be accepted at the edge ending the first IDLE cycle after done.
- At most one eject line is high in any cycle.

## Configuration
- Macro COIN_DISPENSER_COUNT_EN, defined:
  - Adds outputs cnt5, cnt2, cnt1 (8 bits each), counting coins ejected per denomination.
  - Each counter increments on the first PULSE cycle of its coin and saturates at 255.
  - Counters are cleared only by reset.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package coin_pkg holds:
  - the state enum;
  - the coin-select typedef (NONE, C5, C2, C1);
  - denomination constants 5, 2 and 1.
- One sub-module, coin_pulse_timer:
  - loadable down-counter;
  - loaded with PULSE_CYC or GAP_CYC;
  - asserts expire on its last cycle.
- The FSM, remaining register and greedy selector stay in coin_dispenser.

## Test plan
- Amount 8, all hoppers stocked, defaults → eject5, eject2, eject1 in that order, each high 4 cycles with 4-cycle gaps; done in cycle 29; short_amt=0.
- Amount 0 → no eject activity; done in cycle 2; short_amt=0; req_ready back to 1 in cycle 3.
- Amount 4, empty2=1 → four eject1 pulses; done in cycle 38; short_amt=0.
- Amount 6, empty1=1 → one eject5 pulse; done in cycle 11; short_amt=1.
- Amount 10, reset asserted in cycle 3 (mid eject5) → eject5 drops immediately; busy=0; no done; the next request of 2 pays one eject2 normally.
- req_valid held high with a new amount while busy → ignored (req_ready=0); the original payout completes unchanged. With COIN_DISPENSER_COUNT_EN, cnt5, cnt2 and cnt1 match the pulses issued.

Source files
------------

// File: rtl/coin_pkg.sv
// coin_pkg: shared state, coin-select types and denominations for the coin dispenser
package coin_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  typedef enum logic [1:0] {NONE, C5, C2, C1} coin_t;
  localparam logic [7:0] DEN5 = 8'd5;
  localparam logic [7:0] DEN2 = 8'd2;
  localparam logic [7:0] DEN1 = 8'd1;
  function automatic logic [7:0] coin_val(coin_t c);
    return c == C5 ? DEN5 : c == C2 ? DEN2 : c == C1 ? DEN1 : 8'd0;
  endfunction
endpackage

// File: rtl/coin_dispenser_if.sv
// coin_dispenser_if: change request, hopper and status signals between controller and dispenser
interface coin_dispenser_if #(parameter int AMT_W = 8);
  logic req_valid, req_ready;
  logic [AMT_W-1:0] req_amount, short_amt;
  logic empty5, empty2, empty1;
  logic eject5, eject2, eject1;
  logic busy, done;
  modport master(output req_valid, req_amount, empty5, empty2, empty1,
                 input req_ready, eject5, eject2, eject1, busy, done, short_amt);
  modport slave(input req_valid, req_amount, empty5, empty2, empty1,
                output req_ready, eject5, eject2, eject1, busy, done, short_amt);
endinterface

// File: rtl/coin_pulse_timer.sv
// coin_pulse_timer: loadable down-counter, expire marks the last cycle of a loaded interval
module coin_pulse_timer #(parameter int W = 3) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= load ? load_val : cnt != '0 ? cnt - W'(1) : cnt;
  assign expire = cnt == W'(1);
endmodule

// File: rtl/coin_dispenser.sv
// coin_dispenser: greedy 5/2/1 change payout sequencer; COIN_DISPENSER_COUNT_EN adds per-coin counters
module coin_dispenser import coin_pkg::*; #(
  parameter int AMT_W     = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic clk,
  input  logic reset,
  coin_dispenser_if.slave bus
`ifdef COIN_DISPENSER_COUNT_EN
  ,
  output logic [7:0] cnt5,
  output logic [7:0] cnt2,
  output logic [7:0] cnt1
`endif
);
  localparam int MAXC = PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC;
  localparam int CW = $clog2(MAXC + 1);
  state_t state, next;
  coin_t coin, coin_nx, pick;
  logic [AMT_W-1:0] remaining, rem_nx;
  logic load, expire;
  logic [CW-1:0] load_val;
  coin_pulse_timer #(.W(CW)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .expire(expire)
  );
  always_comb
    pick = remaining >= AMT_W'(DEN5) && !bus.empty5 ? C5 :
           remaining >= AMT_W'(DEN2) && !bus.empty2 ? C2 :
           remaining >= AMT_W'(DEN1) && !bus.empty1 ? C1 : NONE;
  always_comb begin
    next = state;
    coin_nx = coin;
    rem_nx = remaining;
    load = 1'b0;
    load_val = CW'(PULSE_CYC);
    case (state)
      IDLE: if (bus.req_valid) begin
        next = SELECT;
        rem_nx = bus.req_amount;
      end
      SELECT: begin
        coin_nx = pick;
        next = pick == NONE ? DONE : PULSE;
        load = pick != NONE;
        rem_nx = remaining - AMT_W'(coin_val(pick));
      end
      PULSE: if (expire) begin
        next = GAP;
        load = 1'b1;
        load_val = CW'(GAP_CYC);
      end
      GAP: next = expire ? SELECT : GAP;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // outputs are registered from the next-state decode so they line up with the state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      coin <= NONE;
      remaining <= '0;
      bus.eject5 <= 1'b0;
      bus.eject2 <= 1'b0;
      bus.eject1 <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.short_amt <= '0;
    end else begin
      state <= next;
      coin <= coin_nx;
      remaining <= rem_nx;
      bus.eject5 <= next == PULSE && coin_nx == C5;
      bus.eject2 <= next == PULSE && coin_nx == C2;
      bus.eject1 <= next == PULSE && coin_nx == C1;
      bus.busy <= next != IDLE;
      bus.done <= next == DONE;
      bus.req_ready <= next == IDLE;
      bus.short_amt <= next == DONE ? remaining :
                       state == IDLE && bus.req_valid ? '0 : bus.short_amt;
    end
`ifdef COIN_DISPENSER_COUNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt5 <= '0;
      cnt2 <= '0;
      cnt1 <= '0;
    end else if (state == SELECT) begin
      cnt5 <= cnt5 + {7'd0, pick == C5 && cnt5 != 8'hff};
      cnt2 <= cnt2 + {7'd0, pick == C2 && cnt2 != 8'hff};
      cnt1 <= cnt1 + {7'd0, pick == C1 && cnt1 != 8'hff};
    end
`endif
endmodule

// File: tb/tb_coin_dispenser.sv
// tb_coin_dispenser: directed payout scenarios with hand-computed eject timelines
module tb_coin_dispenser;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0, errors = 0;
  logic [2:0] obs [0:199];
  int done_cyc, ndone, ready_bad;
  logic [7:0] sh_obs;
  logic rdy_after;
  coin_dispenser_if #(.AMT_W(8)) bus ();
`ifdef COIN_DISPENSER_COUNT_EN
  logic [7:0] cnt5, cnt2, cnt1;
  coin_dispenser dut (.clk(clk), .reset(reset), .bus(bus), .cnt5(cnt5), .cnt2(cnt2), .cnt1(cnt1));
`else
  coin_dispenser dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_eject(int c, logic [11:0] coins, int n);
    int k, p;
    if (c < 2) return 3'b000;
    k = (c - 2) / 9;
    p = (c - 2) % 9;
    return (k < n && p < 4) ? coins[3*k +: 3] : 3'b000;
  endfunction

  task automatic run(input logic [7:0] amt, input logic [2:0] emp, input bit hold, input logic [7:0] amt2);
    @(negedge clk);
    {bus.empty5, bus.empty2, bus.empty1} = emp;
    bus.req_amount = amt;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) bus.req_amount = amt2;
    else bus.req_valid = 1'b0;
    done_cyc = -1;
    ndone = 0;
    ready_bad = 0;
    rdy_after = 1'b0;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      obs[c] = {bus.eject5, bus.eject2, bus.eject1};
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c;
          sh_obs = bus.short_amt;
        end
      end
      if (done_cyc < 0 && bus.req_ready) ready_bad++;
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        rdy_after = bus.req_ready;
        bus.req_valid = 1'b0;
        break;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0;
    bus.req_amount = '0;
    {bus.empty5, bus.empty2, bus.empty1} = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.eject5, bus.eject2, bus.eject1} !== 3'b000) begin errors++; $display("FAIL reset_eject got %b want 000", {bus.eject5, bus.eject2, bus.eject1}); end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", bus.busy, bus.done); end
    checks++;
    if (bus.short_amt !== 8'd0) begin errors++; $display("FAIL reset_short got %0d want 0", bus.short_amt); end
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
`ifdef COIN_DISPENSER_COUNT_EN
    checks++;
    if ({cnt5, cnt2, cnt1} !== 24'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", {cnt5, cnt2, cnt1}); end
`endif
  endtask

  task automatic test_greedy;
    int bad = 0;
    run(8'd8, 3'b000, 1'b0, 8'd0);
    for (int c = 1; c <= 29; c++) if (obs[c] !== exp_eject(c, {3'b000, 3'b001, 3'b010, 3'b100}, 3)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL greedy8_trace got %0d bad cycles want 0", bad); end
    checks++;
    if (done_cyc != 29 || ndone != 1) begin errors++; $display("FAIL greedy8_done got cycle %0d count %0d want 29 1", done_cyc, ndone); end
    checks++;
    if (sh_obs !== 8'd0) begin errors++; $display("FAIL greedy8_short got %0d want 0", sh_obs); end
  endtask

  task automatic test_zero;
    int bad = 0;
    run(8'd0, 3'b000, 1'b0, 8'd0);
    for (int c = 1; c <= 3; c++) if (obs[c] !== 3'b000) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL zero_trace got %0d bad cycles want 0", bad); end
    checks++;
    if (done_cyc != 2) begin errors++; $display("FAIL zero_done got %0d want 2", done_cyc); end
    checks++;
    if (sh_obs !== 8'd0 || rdy_after !== 1'b1) begin errors++; $display("FAIL zero_short_ready got %0d %b want 0 1", sh_obs, rdy_after); end
  endtask

  task automatic test_empty2;
    int bad = 0;
    run(8'd4, 3'b010, 1'b0, 8'd0);
    for (int c = 1; c <= 38; c++) if (obs[c] !== exp_eject(c, {3'b001, 3'b001, 3'b001, 3'b001}, 4)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL empty2_trace got %0d bad cycles want 0", bad); end
    checks++;
    if (done_cyc != 38 || sh_obs !== 8'd0) begin errors++; $display("FAIL empty2_done got cycle %0d short %0d want 38 0", done_cyc, sh_obs); end
  endtask

  task automatic test_empty1_short;
    int bad = 0;
    run(8'd6, 3'b001, 1'b0, 8'd0);
    for (int c = 1; c <= 11; c++) if (obs[c] !== exp_eject(c, {9'd0, 3'b100}, 1)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL empty1_trace got %0d bad cycles want 0", bad); end
    checks++;
    if (done_cyc != 11) begin errors++; $display("FAIL empty1_done got %0d want 11", done_cyc); end
    checks++;
    if (sh_obs !== 8'd1) begin errors++; $display("FAIL empty1_short got %0d want 1", sh_obs); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.short_amt !== 8'd1 || bus.done !== 1'b0) begin errors++; $display("FAIL empty1_hold got short %0d done %b want 1 0", bus.short_amt, bus.done); end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    logic saw;
    @(negedge clk);
    {bus.empty5, bus.empty2, bus.empty1} = 3'b000;
    bus.req_amount = 8'd10;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    saw = bus.eject5;
    checks++;
    if (saw !== 1'b1) begin errors++; $display("FAIL midreset_pre got eject5 %b want 1", saw); end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.eject5, bus.eject2, bus.eject1, bus.busy, bus.done} !== 5'b0) begin errors++; $display("FAIL midreset_out got %b want 00000", {bus.eject5, bus.eject2, bus.eject1, bus.busy, bus.done}); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done || bus.eject5) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles want 0", bad); end
    bad = 0;
    run(8'd2, 3'b000, 1'b0, 8'd0);
    for (int c = 1; c <= 11; c++) if (obs[c] !== exp_eject(c, {9'd0, 3'b010}, 1)) bad++;
    checks++;
    if (bad != 0 || done_cyc != 11 || sh_obs !== 8'd0) begin errors++; $display("FAIL midreset_next got bad %0d done %0d short %0d want 0 11 0", bad, done_cyc, sh_obs); end
  endtask

  task automatic test_busy_ignore;
    int bad = 0;
    run(8'd7, 3'b000, 1'b1, 8'd3);
    for (int c = 1; c <= 20; c++) if (obs[c] !== exp_eject(c, {6'd0, 3'b010, 3'b100}, 2)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_trace got %0d bad cycles want 0", bad); end
    checks++;
    if (done_cyc != 20 || sh_obs !== 8'd0) begin errors++; $display("FAIL busy_done got cycle %0d short %0d want 20 0", done_cyc, sh_obs); end
    checks++;
    if (ready_bad != 0) begin errors++; $display("FAIL busy_ready got %0d ready cycles want 0", ready_bad); end
`ifdef COIN_DISPENSER_COUNT_EN
    checks++;
    if ({cnt5, cnt2, cnt1} !== {8'd1, 8'd2, 8'd0}) begin errors++; $display("FAIL busy_cnt got %0d %0d %0d want 1 2 0", cnt5, cnt2, cnt1); end
`endif
  endtask

  initial begin
    test_reset;
    test_greedy;
    test_zero;
    test_empty2;
    test_empty1_short;
    test_reset_mid;
    test_busy_ignore;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
